// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with registered forwarding selects and load-use hazard detection.
// Optional saturating stall counter enabled by defining STALL_CNT_EN.
module id_ex_fwd_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rt_data_q, ex_imm_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              ex_reg_write_q, ex_mem_read_q;
  logic [1:0]        fwd_a_q, fwd_b_q;
  logic [1:0]        fwd_a_d, fwd_b_d;
  logic              hz, bubble;
  logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic              ex_writes, mem_writes;

  assign ex_writes  = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0);
  assign mem_writes = exmem_reg_write & (exmem_rd != '0);

  assign hz = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & id_valid &
              ((ex_rd_q == id_rs) | (ex_rd_q == id_rt));
  assign stall  = hz & ~flush;
  assign bubble = flush | hz;

  assign ex_hit_a  = ex_writes  & (ex_rd_q  == id_rs);
  assign ex_hit_b  = ex_writes  & (ex_rd_q  == id_rt);
  assign mem_hit_a = mem_writes & (exmem_rd == id_rs);
  assign mem_hit_b = mem_writes & (exmem_rd == id_rt);

  // The nearer producer (currently in EX) takes precedence over EX/MEM.
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (ex_hit_a)       fwd_a_d = 2'd2;
    else if (mem_hit_a) fwd_a_d = 2'd1;
    if (ex_hit_b)       fwd_b_d = 2'd2;
    else if (mem_hit_b) fwd_b_d = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      fwd_a_q        <= 2'd0;
      fwd_b_q        <= 2'd0;
    end else if (bubble) begin
      // Data registers hold; only control is cleared.
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      fwd_a_q        <= 2'd0;
      fwd_b_q        <= 2'd0;
    end else begin
      ex_valid_q     <= id_valid;
      ex_rs_data_q   <= id_rs_data;
      ex_rt_data_q   <= id_rt_data;
      ex_imm_q       <= id_imm;
      ex_rd_q        <= id_rd;
      ex_reg_write_q <= id_valid & id_reg_write;
      ex_mem_read_q  <= id_valid & id_mem_read;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count_q <= '0;
    else if (stall && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_q <= stall_count_q + 32'd1;
  end

  assign stall_count = stall_count_q;
`endif

  assign ex_valid     = ex_valid_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Bench for id_ex_fwd_reg: directed vector table, mid-stall reset, random traffic vs reference model.
module tb_id_ex_fwd_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, exmem_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, exmem_reg_write;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rd;
  logic [1:0]  fwd_a, fwd_b;
`ifdef STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  id_ex_fwd_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .stall(stall), .ex_valid(ex_valid),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference view of what instruction sits in EX.
  typedef struct {
    bit          valid, rw, mr;
    bit [4:0]    rd;
    bit [31:0]   rsd, rtd, imm;
    int          fa, fb;
  } ex_slot_t;

  ex_slot_t    m;
  int unsigned m_cnt;
  bit          m_stall;

  typedef struct {
    bit       flush, vld;
    bit [4:0] rs, rt, rd;
    bit       rw, mr, xrw;
    bit [4:0] xrd;
    bit       e_stall, e_valid, e_rw;
    int       e_fa, e_fb;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic ex_slot_t empty_slot();
    ex_slot_t s;
    s.valid = 0; s.rw = 0; s.mr = 0; s.rd = 0;
    s.rsd = 0; s.rtd = 0; s.imm = 0; s.fa = 0; s.fb = 0;
    return s;
  endfunction

  // Producer list ordered nearest first: EX instruction, then EX/MEM.
  function automatic int source_of(input bit [4:0] idx);
    if (idx == 0) return 0;
    if (m.valid && m.rw && m.rd == idx) return 2;
    if (exmem_reg_write && exmem_rd == idx) return 1;
    return 0;
  endfunction

  function automatic bit load_use();
    if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 0;
    return (m.rd == id_rs) || (m.rd == id_rt);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
    chk({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk({tag, ".ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, m.mr});
    chk({tag, ".fwd_a"}, {30'd0, fwd_a}, m.fa);
    chk({tag, ".fwd_b"}, {30'd0, fwd_b}, m.fb);
    if (m.valid) begin
      chk({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
      chk({tag, ".ex_rs_data"}, ex_rs_data, m.rsd);
      chk({tag, ".ex_rt_data"}, ex_rt_data, m.rtd);
      chk({tag, ".ex_imm"}, ex_imm, m.imm);
    end
`ifdef STALL_CNT_EN
    chk({tag, ".stall_count"}, stall_count, m_cnt);
`endif
  endtask

  // Drive one ID cycle starting at a falling edge, check stall, clock, check registered state.
  task automatic step(input bit fl, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                      input bit [4:0] rd, input bit rw, input bit mr, input bit xrw,
                      input bit [4:0] xrd, input bit [31:0] rsd, input bit [31:0] rtd,
                      input bit [31:0] imm, input string tag);
    ex_slot_t nx;
    @(negedge clk);
    flush = fl; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; exmem_reg_write = xrw; exmem_rd = xrd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    #1;
    m_stall = load_use() && !fl;
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, m_stall});
    nx = m;
    if (fl || load_use()) begin
      nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.fa = 0; nx.fb = 0;
    end else begin
      nx.valid = v; nx.rw = v && rw; nx.mr = v && mr; nx.rd = rd;
      nx.rsd = rsd; nx.rtd = rtd; nx.imm = imm;
      nx.fa = source_of(rs); nx.fb = source_of(rt);
    end
    if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    @(posedge clk);
    m = nx;
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_reg_write = 0; id_mem_read = 0;
    exmem_reg_write = 0; exmem_rd = 0;
    m = empty_slot(); m_cnt = 0;

    tv[0]  = '{0,1, 1, 2, 5,1,0,0,0,  0,1,1, 0,0};
    tv[1]  = '{0,1, 5, 6, 8,1,0,0,0,  0,1,1, 2,0};
    tv[2]  = '{0,1, 9, 7, 7,1,0,1,7,  0,1,1, 0,1};
    tv[3]  = '{0,1, 0, 7, 3,1,1,1,7,  0,1,1, 0,2};
    tv[4]  = '{0,1, 3, 4,10,1,0,1,7,  1,0,0, 0,0};
    tv[5]  = '{0,1, 3, 4,10,1,0,1,3,  0,1,1, 1,0};
    tv[6]  = '{0,1, 0, 0, 0,1,1,0,0,  0,1,1, 0,0};
    tv[7]  = '{0,1, 0, 0, 2,1,0,1,0,  0,1,1, 0,0};
    tv[8]  = '{0,1, 1, 1,11,1,1,0,0,  0,1,1, 0,0};
    tv[9]  = '{1,1,11, 1,12,1,0,0,0,  0,0,0, 0,0};
    tv[10] = '{0,0, 1, 1, 1,1,1,0,0,  0,0,0, 0,0};

    #12;
    check_model("reset_hold");
    chk("reset_hold.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model("reset_rel");

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tv[i].flush, tv[i].vld, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].rw, tv[i].mr,
           tv[i].xrw, tv[i].xrd, 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, tag);
      chk({tag, ".tbl_stall"}, {31'd0, m_stall}, {31'd0, tv[i].e_stall});
      chk({tag, ".tbl_valid"}, {31'd0, ex_valid}, {31'd0, tv[i].e_valid});
      chk({tag, ".tbl_rw"}, {31'd0, ex_reg_write}, {31'd0, tv[i].e_rw});
      chk({tag, ".tbl_fa"}, {30'd0, fwd_a}, tv[i].e_fa);
      chk({tag, ".tbl_fb"}, {30'd0, fwd_b}, tv[i].e_fb);
    end
`ifdef STALL_CNT_EN
    chk("tbl.stall_count", stall_count, 32'd1);
`endif

    // Reset arriving while a load-use stall is active.
    step(0, 1, 1, 2, 3, 1, 1, 0, 0, 32'hA, 32'hB, 32'hC, "mid.load");
    @(negedge clk);
    flush = 0; id_valid = 1; id_rs = 3; id_rt = 9; id_rd = 4;
    id_reg_write = 1; id_mem_read = 0; exmem_reg_write = 0; exmem_rd = 0;
    #1;
    chk("mid.stall_before", {31'd0, stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    m = empty_slot(); m_cnt = 0;
    chk("mid.stall_after_rst", {31'd0, stall}, 32'd0);
    check_model("mid.rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
